zapper_detector: RTL and testbench
==================================

// Module: zapper_detector
// PURPOSE
// - Light-gun front end for Duck Hunt. Produces the trigger/detect pair consumed by the screen pattern generator.
// - Debounces the zapper trigger and synchronizes the photodiode input.
// - Mirrors the shot flash sequence frame by frame (black frame, then white hit-box frame).
// - Declares a hit only when the white frame is seen bright and the black frame was seen dark.
// PARAMETERS
// DEBOUNCE_CYCLES  250000  consecutive stable clk samples needed to accept a trigger change (10 ms @ 25 MHz)
// HIT_THRESHOLD    64      light samples in the white frame needed to declare a hit
// BLACK_MAX        16      max light samples tolerated in the black frame (rejects aiming at a lamp)
// LIGHT_ACT_LOW    1       1: light_in low means light seen (NES zapper)
// CNT_W            16      width of the light sample counters
// PORTS
// clk          in   1  pixel clock
// rst_n        in   1  asynchronous active-low reset
// frame_start  in   1  1-clk pulse at frame boundary (same event as screen_reset)
// valid        in   1  active-video qualifier
// trigger_in   in   1  raw trigger button, asynchronous, active-high
// light_in     in   1  raw photodiode output, asynchronous, polarity per LIGHT_ACT_LOW
// trigger      out  1  debounced trigger level
// detect       out  1  hit flag; high from threshold crossing until the frame_start that ends the white frame
// shot_hit     out  1  1-clk pulse on that frame_start when the shot hit
// shot_miss    out  1  1-clk pulse on that frame_start when the shot missed
// phase        out  2  current zapper_phase_t
// BEHAVIOUR
// - Reset values: all outputs 0; phase = Z_IDLE; counters 0. Reset mid-sequence aborts the shot and emits no pulse.
// - trigger_in and light_in each pass through a 2-FF synchronizer.
// - light = synced light_in ^ LIGHT_ACT_LOW.
// - Debounce:
//   - counter resets whenever the synced trigger equals the current trigger output;
//   - trigger toggles when the counter reaches DEBOUNCE_CYCLES-1;
//   - latency = 2 + DEBOUNCE_CYCLES clk from a stable edge.
// - FSM transitions occur only on clk edges with frame_start=1:
//   - Z_IDLE: trigger=1 -> Z_BLACK; otherwise stay.
//   - Z_BLACK -> Z_WHITE, unconditionally.
//   - Z_WHITE -> Z_HELD, unconditionally.
//   - Z_HELD: trigger=0 -> Z_IDLE; otherwise stay. A held trigger fires only one shot.
// - A trigger press mid-frame waits for the next frame_start.
// - Releasing the trigger during Z_BLACK or Z_WHITE does not abort the sequence.
// - Counting:
//   - black_cnt increments on valid & light & !frame_start in Z_BLACK; white_cnt does the same in Z_WHITE.
//   - Both counters saturate at 2^CNT_W-1.
//   - Both clear on the frame_start that enters Z_BLACK.
//   - frame_start has priority over counting on the same cycle.
// - detect:
//   - Rises the clk after white_cnt reaches HIT_THRESHOLD while in Z_WHITE, if black_cnt <= BLACK_MAX.
//   - Stays high through the frame_start edge leaving Z_WHITE, so consumers sampling on that event see 1.
//   - Clears on that same edge and is never asserted outside Z_WHITE.
// - On the frame_start leaving Z_WHITE, exactly one of shot_hit / shot_miss pulses for 1 clk:
//   - hit = white_cnt >= HIT_THRESHOLD && black_cnt <= BLACK_MAX;
//   - otherwise miss.
// - Arithmetic: counters are unsigned CNT_W; comparisons are zero-extended to CNT_W.
//   HIT_THRESHOLD and BLACK_MAX must be < 2^CNT_W (checked by elaboration assertion).
// STRUCTURE
// - zapper_pkg: typedef enum logic[1:0] {Z_IDLE, Z_BLACK, Z_WHITE, Z_HELD} zapper_phase_t.
//   The pattern generator imports the same type for its flash state.
// - zapper_pkg: localparam SYNC_STAGES = 2.
// - Sub-module zapper_debounce (params DEBOUNCE_CYCLES, SYNC_STAGES): ports clk, rst_n, in, out.
//   It contains the trigger synchronizer and debounce counter.
// - Top level: light synchronizer, phase FSM, two saturating counters, detect and pulse registers.
// TESTING (DEBOUNCE_CYCLES=4, HIT_THRESHOLD=8, BLACK_MAX=2, frame = 100 clk, valid = 80 of them)
// 1. trigger_in bounces 1-0-1 at 1-clk intervals, then holds 1 -> trigger rises exactly 6 clk after the last edge, with no glitch.
// 2. Press; black frame has 0 light samples; white frame has 10 -> detect rises after the 8th sample,
//    is high at the next frame_start edge, shot_hit pulses once, phase = Z_HELD.
// 3. Black frame has 5 light samples; white frame has 80 -> detect never rises, shot_miss pulses once.
// 4. Trigger held for 5 frames -> one sequence only, stays Z_HELD.
//    Release, then press again -> new sequence, with counters cleared.
// 5. rst_n asserted mid-Z_WHITE after 8 samples -> all outputs 0 immediately, phase = Z_IDLE, no pulse.
// 6. Force light and valid high for 70000 clk in Z_WHITE (CNT_W=16) -> white_cnt saturates at 65535 without wrap; hit reported.

Source files
------------

// File: rtl/zapper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zapper_pkg
// Description : Shared types and constants for the zapper light-gun front end.
//               The screen pattern generator imports the same phase type so
//               its flash sequence and the detector stay in lock-step.
// Contents    : zapper_phase_t - shot phase (idle, black, white, held)
//               SYNC_STAGES    - depth of the input synchronizers
//               fits_width()   - true when a value is representable in w bits
// Revision    : 1.0 - initial release
// ============================================================================
package zapper_pkg;

  typedef enum logic [1:0] {
    Z_IDLE  = 2'd0,
    Z_BLACK = 2'd1,
    Z_WHITE = 2'd2,
    Z_HELD  = 2'd3
  } zapper_phase_t;

  localparam int SYNC_STAGES = 2;

  // Used by the elaboration checks on the counter thresholds.
  function automatic bit fits_width(input longint value, input int width);
    return (value >= 0) && (value < (64'sd1 <<< width));
  endfunction

endpackage
`default_nettype wire

// File: rtl/zapper_debounce.sv
`default_nettype none
// ============================================================================
// Module      : zapper_debounce
// Description : Synchronizes an asynchronous button input and accepts a level
//               change only after it has been stable for DEBOUNCE_CYCLES
//               consecutive clk samples. Latency from a clean input edge to
//               the output edge is SYNC_STAGES + DEBOUNCE_CYCLES clk.
// Ports       : clk   in  clock
//               rst_n in  asynchronous active-low reset
//               in    in  raw asynchronous button level
//               out   out debounced level (0 after reset)
// Revision    : 1.0 - initial release
// ============================================================================
module zapper_debounce import zapper_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES     = zapper_pkg::SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic out
);

  localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_chk_cycles
    $error("zapper_debounce: DEBOUNCE_CYCLES must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("zapper_debounce: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  logic [CW-1:0]          cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in};
    end
  end

  assign synced = sync[SYNC_STAGES-1];

  // The counter only runs while the synchronized input disagrees with the
  // accepted level; any bounce back to the accepted level restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (synced == out) begin
      cnt <= '0;
    end else if (cnt == CNT_TOP) begin
      cnt <= '0;
      out <= ~out;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/zapper_detector.sv
`default_nettype none
// ============================================================================
// Module      : zapper_detector
// Description : Duck Hunt light-gun front end. Debounces the trigger,
//               synchronizes the photodiode, follows the shot flash sequence
//               frame by frame (black frame, then white hit-box frame) and
//               declares a hit only when the white frame was bright and the
//               black frame was dark.
// Ports       : clk         in  pixel clock
//               rst_n       in  asynchronous active-low reset
//               frame_start in  1-clk pulse at the frame boundary
//               valid       in  active-video qualifier
//               trigger_in  in  raw trigger button, asynchronous, active-high
//               light_in    in  raw photodiode, polarity set by LIGHT_ACT_LOW
//               trigger     out debounced trigger level
//               detect      out hit flag during the white frame
//               shot_hit    out 1-clk pulse at the end of a hitting shot
//               shot_miss   out 1-clk pulse at the end of a missing shot
//               phase       out current shot phase
// Revision    : 1.0 - initial release
// ============================================================================
module zapper_detector import zapper_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HIT_THRESHOLD   = 64,
  parameter int BLACK_MAX       = 16,
  parameter int LIGHT_ACT_LOW   = 1,
  parameter int CNT_W           = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          valid,
  input  logic          trigger_in,
  input  logic          light_in,
  output logic          trigger,
  output logic          detect,
  output logic          shot_hit,
  output logic          shot_miss,
  output zapper_phase_t phase
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] HIT_LIMIT  = CNT_W'(HIT_THRESHOLD);
  localparam logic [CNT_W-1:0] BLACK_LIM  = CNT_W'(BLACK_MAX);
  localparam logic             LIGHT_LOW  = (LIGHT_ACT_LOW != 0);

  if (!fits_width(longint'(HIT_THRESHOLD), CNT_W)) begin : g_chk_hit
    $error("zapper_detector: HIT_THRESHOLD does not fit in CNT_W bits");
  end
  if (!fits_width(longint'(BLACK_MAX), CNT_W)) begin : g_chk_black
    $error("zapper_detector: BLACK_MAX does not fit in CNT_W bits");
  end

  // --------------------------------------------------------------------------
  // Trigger debounce
  // --------------------------------------------------------------------------
  zapper_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (trigger_in),
    .out   (trigger)
  );

  // --------------------------------------------------------------------------
  // Photodiode synchronizer. Reset to the "no light" level so the first clks
  // after reset never look like a bright sample.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] light_sync;
  logic                   light;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      light_sync <= {SYNC_STAGES{LIGHT_LOW}};
    end else begin
      light_sync <= {light_sync[SYNC_STAGES-2:0], light_in};
    end
  end

  assign light = light_sync[SYNC_STAGES-1] ^ LIGHT_LOW;

  // --------------------------------------------------------------------------
  // Shot phase FSM. Every transition is tied to a frame boundary so the
  // detector walks through the same frames the pattern generator draws.
  // --------------------------------------------------------------------------
  zapper_phase_t    state;
  zapper_phase_t    state_next;
  logic             enter_black;
  logic             leave_white;
  logic             hit_now;
  logic [CNT_W-1:0] black_cnt;
  logic [CNT_W-1:0] white_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= Z_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    enter_black = 1'b0;
    leave_white = 1'b0;
    if (frame_start) begin
      case (state)
        Z_IDLE: begin
          if (trigger) begin
            state_next  = Z_BLACK;
            enter_black = 1'b1;
          end
        end
        Z_BLACK: state_next = Z_WHITE;
        Z_WHITE: begin
          state_next  = Z_HELD;
          leave_white = 1'b1;
        end
        Z_HELD: begin
          if (!trigger) begin
            state_next = Z_IDLE;
          end
        end
        default: state_next = Z_IDLE;
      endcase
    end
  end

  assign phase = state;

  // --------------------------------------------------------------------------
  // Light sample counters. The frame_start cycle itself is never counted, and
  // the counts are kept after the white frame so the verdict can use them.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      black_cnt <= '0;
      white_cnt <= '0;
    end else if (enter_black) begin
      black_cnt <= '0;
      white_cnt <= '0;
    end else if (!frame_start && valid && light) begin
      if (state == Z_BLACK && black_cnt != CNT_MAX) begin
        black_cnt <= black_cnt + CNT_W'(1);
      end
      if (state == Z_WHITE && white_cnt != CNT_MAX) begin
        white_cnt <= white_cnt + CNT_W'(1);
      end
    end
  end

  assign hit_now = (white_cnt >= HIT_LIMIT) && (black_cnt <= BLACK_LIM);

  // --------------------------------------------------------------------------
  // Detect and verdict pulses. detect is cleared by the same edge that leaves
  // the white frame, so anything sampling on that frame_start still sees it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      detect    <= 1'b0;
      shot_hit  <= 1'b0;
      shot_miss <= 1'b0;
    end else begin
      detect    <= (state == Z_WHITE) && !frame_start && hit_now;
      shot_hit  <= leave_white && hit_now;
      shot_miss <= leave_white && !hit_now;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zapper_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_zapper_detector
// Description : Directed self-checking bench for zapper_detector with
//               DEBOUNCE_CYCLES=4, HIT_THRESHOLD=8, BLACK_MAX=2, 100-clk
//               frames with 80 valid clks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zapper_detector;

  localparam logic [1:0] P_IDLE  = 2'd0;
  localparam logic [1:0] P_BLACK = 2'd1;
  localparam logic [1:0] P_WHITE = 2'd2;
  localparam logic [1:0] P_HELD  = 2'd3;

  logic       clk         = 1'b0;
  logic       rst_n       = 1'b0;
  logic       frame_start = 1'b0;
  logic       valid       = 1'b0;
  logic       trigger_in  = 1'b0;
  logic       light_in    = 1'b1;
  logic       trigger;
  logic       detect;
  logic       shot_hit;
  logic       shot_miss;
  logic [1:0] phase;

  always #5 clk = ~clk;

  zapper_detector #(
    .DEBOUNCE_CYCLES (4),
    .HIT_THRESHOLD   (8),
    .BLACK_MAX       (2),
    .LIGHT_ACT_LOW   (1),
    .CNT_W           (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .valid       (valid),
    .trigger_in  (trigger_in),
    .light_in    (light_in),
    .trigger     (trigger),
    .detect      (detect),
    .shot_hit    (shot_hit),
    .shot_miss   (shot_miss),
    .phase       (phase)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Per-frame observations
  int obs_det0;      // detect just before this frame's frame_start edge
  int obs_phase1;    // phase just after this frame's frame_start edge
  int obs_hits;      // shot_hit clks seen during the frame
  int obs_miss;      // shot_miss clks seen during the frame
  int obs_detfirst;  // first clk index (>=1) with detect high, -1 if none

  // One frame: frame_start at clk 0, valid on clks 10..len-11, light_in
  // driven active two clks ahead of the first n_light valid clks so the
  // synchronized light lines up with valid.
  task automatic run_frame(input int n_light, input int len, input int stop_at);
    obs_det0     = 0;
    obs_phase1   = 0;
    obs_hits     = 0;
    obs_miss     = 0;
    obs_detfirst = -1;
    for (int c = 0; c < stop_at; c++) begin
      @(negedge clk);
      if (c == 0) obs_det0 = int'(detect);
      if (c == 1) obs_phase1 = int'(phase);
      if (shot_hit) obs_hits++;
      if (shot_miss) obs_miss++;
      if (c >= 1 && detect && obs_detfirst < 0) obs_detfirst = c;
      frame_start = (c == 0);
      valid       = (c >= 10 && c < len - 10);
      light_in    = (c >= 8 && c < 8 + n_light) ? 1'b0 : 1'b1;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check_val("rst_trigger", trigger, 0);
    check_val("rst_detect", detect, 0);
    check_val("rst_hit", shot_hit, 0);
    check_val("rst_miss", shot_miss, 0);
    check_val("rst_phase", phase, P_IDLE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---------------- 1: debounce with bounce ----------------
    trigger_in = 1'b1;
    @(negedge clk) trigger_in = 1'b0;
    @(negedge clk) trigger_in = 1'b1;
    first = -1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (trigger && first < 0) first = k;
    end
    check_val("deb_rise_clk", first, 6);
    check_val("deb_hold", trigger, 1);

    // ---------------- 2: clean hit ----------------
    run_frame(0, 100, 100);
    check_val("t2_black_phase", obs_phase1, P_BLACK);
    run_frame(10, 100, 100);
    check_val("t2_white_phase", obs_phase1, P_WHITE);
    check_val("t2_det_in_black", obs_det0, 0);
    check_val("t2_det_rise", obs_detfirst, 19);
    run_frame(0, 100, 100);
    check_val("t2_det_at_edge", obs_det0, 1);
    check_val("t2_hit", obs_hits, 1);
    check_val("t2_miss", obs_miss, 0);
    check_val("t2_held_phase", obs_phase1, P_HELD);
    check_val("t2_det_after", obs_detfirst, -1);

    // ---------------- 3: lamp rejection ----------------
    trigger_in = 1'b0;
    run_frame(0, 100, 100);
    check_val("t3_still_held", obs_phase1, P_HELD);
    run_frame(0, 100, 100);
    check_val("t3_idle", obs_phase1, P_IDLE);
    trigger_in = 1'b1;
    run_frame(0, 100, 100);
    check_val("t3_wait_deb", obs_phase1, P_IDLE);
    run_frame(5, 100, 100);
    check_val("t3_black", obs_phase1, P_BLACK);
    run_frame(80, 100, 100);
    check_val("t3_white", obs_phase1, P_WHITE);
    check_val("t3_no_detect", obs_detfirst, -1);
    run_frame(0, 100, 100);
    check_val("t3_det_at_edge", obs_det0, 0);
    check_val("t3_miss", obs_miss, 1);
    check_val("t3_hit", obs_hits, 0);
    check_val("t3_held", obs_phase1, P_HELD);

    // ---------------- 4: held trigger, then re-press ----------------
    run_frame(10, 100, 100);
    check_val("t4_held_a", obs_phase1, P_HELD);
    run_frame(10, 100, 100);
    check_val("t4_held_b", obs_phase1, P_HELD);
    check_val("t4_no_pulse", obs_hits + obs_miss, 0);
    check_val("t4_no_detect", obs_detfirst, -1);
    trigger_in = 1'b0;
    run_frame(0, 100, 100);
    run_frame(0, 100, 100);
    check_val("t4_released", obs_phase1, P_IDLE);
    trigger_in = 1'b1;
    run_frame(0, 100, 100);
    run_frame(0, 100, 100);
    check_val("t4_black", obs_phase1, P_BLACK);
    run_frame(10, 100, 100);
    check_val("t4_det_rise", obs_detfirst, 19);
    run_frame(0, 100, 100);
    check_val("t4_hit", obs_hits, 1);
    check_val("t4_miss", obs_miss, 0);

    // ---------------- 5: reset mid white frame ----------------
    trigger_in = 1'b0;
    run_frame(0, 100, 100);
    run_frame(0, 100, 100);
    trigger_in = 1'b1;
    run_frame(0, 100, 100);
    run_frame(0, 100, 100);
    check_val("t5_black", obs_phase1, P_BLACK);
    run_frame(10, 100, 20);
    check_val("t5_white", obs_phase1, P_WHITE);
    check_val("t5_det_before_rst", obs_detfirst, 19);
    rst_n      = 1'b0;
    trigger_in = 1'b0;
    #1;
    check_val("t5_rst_detect", detect, 0);
    check_val("t5_rst_trigger", trigger, 0);
    check_val("t5_rst_phase", phase, P_IDLE);
    check_val("t5_rst_pulses", {shot_hit, shot_miss}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(10, 100, 100);
    check_val("t5_after_phase", obs_phase1, P_IDLE);
    check_val("t5_after_pulses", obs_hits + obs_miss, 0);
    check_val("t5_after_detect", obs_detfirst, -1);

    // ---------------- 6: white counter saturation ----------------
    trigger_in = 1'b1;
    run_frame(0, 100, 100);
    run_frame(0, 100, 100);
    check_val("t6_black", obs_phase1, P_BLACK);
    run_frame(70000, 70020, 70020);
    check_val("t6_white", obs_phase1, P_WHITE);
    check_val("t6_det_rise", obs_detfirst, 19);
    check_val("t6_white_sat", dut.white_cnt, 65535);
    run_frame(0, 100, 100);
    check_val("t6_det_at_edge", obs_det0, 1);
    check_val("t6_hit", obs_hits, 1);
    check_val("t6_miss", obs_miss, 0);
    check_val("t6_held", obs_phase1, P_HELD);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
